// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state type and decode helpers for the RV64M multiply/divide unit.
package muldiv_pkg;

  localparam logic [7:0] OP_MUL    = 8'd10;
  localparam logic [7:0] OP_MULH   = 8'd11;
  localparam logic [7:0] OP_MULHSU = 8'd12;
  localparam logic [7:0] OP_MULHU  = 8'd13;
  localparam logic [7:0] OP_DIV    = 8'd14;
  localparam logic [7:0] OP_DIVU   = 8'd15;
  localparam logic [7:0] OP_REM    = 8'd16;
  localparam logic [7:0] OP_REMU   = 8'd17;
  localparam logic [7:0] OP_MULW   = 8'd38;
  localparam logic [7:0] OP_DIVW   = 8'd39;
  localparam logic [7:0] OP_DIVUW  = 8'd40;
  localparam logic [7:0] OP_REMW   = 8'd41;
  localparam logic [7:0] OP_REMUW  = 8'd42;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_t;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op >= OP_DIV && op <= OP_REMU) || (op >= OP_DIVW && op <= OP_REMUW);
  endfunction

  function automatic logic is_mul_op(input logic [7:0] op);
    return (op >= OP_MUL && op <= OP_MULHU) || (op == OP_MULW);
  endfunction

  function automatic logic is_w_op(input logic [7:0] op);
    return (op >= OP_MULW && op <= OP_REMUW);
  endfunction

  function automatic logic is_signed_div(input logic [7:0] op);
    return (op == OP_DIV) || (op == OP_REM) || (op == OP_DIVW) || (op == OP_REMW);
  endfunction

  function automatic logic is_rem_op(input logic [7:0] op);
    return (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);
  endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// quotient_o/remainder_o carry the post-step values, so they are final while done_o is high.
module muldiv_divider
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            w_sel_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            done_o
);

  localparam int CW = $clog2(XLEN);

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q;
  logic            w_q;
  logic [XLEN:0]   trial;
  logic [CW-1:0]   last;

  always_comb begin
    last  = w_q ? CW'(31) : CW'(XLEN - 1);
    trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    rem_d = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
    quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
  end

  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;
  assign done_o      = busy_q && (cnt_q == last);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      busy_q <= !done_o;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // 32-bit mode parks the dividend in the top half so the same MSB-first walk applies.
  always_ff @(posedge clk) begin
    if (start_i) begin
      rem_q <= '0;
      quo_q <= w_sel_i ? (dividend_i << (XLEN - 32)) : dividend_i;
      dvs_q <= divisor_i;
      w_q   <= w_sel_i;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV64M multiply/divide unit (fixed-latency multiply, iterative divide).
// Optional `MULDIV_FLUSH_EN adds a flush input that drops any in-flight or pending result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            reset_n,
`ifdef MULDIV_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      instruction,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] mul_result(input logic [7:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ea, eb, prod;
    logic sa, sb;
    sa   = ((op == OP_MULH) || (op == OP_MULHSU)) && a[XLEN-1];
    sb   = (op == OP_MULH) && b[XLEN-1];
    ea   = {{XLEN{sa}}, a};
    eb   = {{XLEN{sb}}, b};
    prod = ea * eb;
    case (op)
      OP_MUL:  return prod[XLEN-1:0];
      OP_MULW: return sext_w(prod[31:0]);
      default: return prod[2*XLEN-1:XLEN];
    endcase
  endfunction

  muldiv_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;

  logic [7:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            opw_q, oprem_q, negq_q, negr_q;

  logic            flush_w, accept;
  logic            w_op, sgn, is_div, is_mul, legal, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_eff, b_eff, a_mag, b_mag, minv, special_res;
  logic [XLEN-1:0] div_quo, div_rem, q_fix, r_fix, sel_res, div_res;
  logic            div_start, div_done;

`ifdef MULDIV_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE) && !flush_w;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;

  // Accept-time decode: operand widening, sign magnitudes and the one-cycle divide cases.
  always_comb begin
    w_op     = is_w_op(instruction);
    sgn      = is_signed_div(instruction);
    is_div   = is_div_op(instruction);
    is_mul   = is_mul_op(instruction);
    legal    = (is_div || is_mul) && !(w_op && (XLEN != 64));
    a_eff    = w_op ? (sgn ? sext_w(rs1[31:0]) : XLEN'(rs1[31:0])) : rs1;
    b_eff    = w_op ? (sgn ? sext_w(rs2[31:0]) : XLEN'(rs2[31:0])) : rs2;
    a_neg    = sgn && a_eff[XLEN-1];
    b_neg    = sgn && b_eff[XLEN-1];
    a_mag    = a_neg ? -a_eff : a_eff;
    b_mag    = b_neg ? -b_eff : b_eff;
    minv     = w_op ? sext_w(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_eff == '0);
    div_ovf  = sgn && (b_eff == '1) && (a_eff == minv);
    if (div_zero) special_res = is_rem_op(instruction) ? a_eff : '1;
    else          special_res = is_rem_op(instruction) ? '0 : a_eff;
    if (w_op) special_res = sext_w(special_res[31:0]);
  end

  assign div_start = accept && legal && is_div && !div_zero && !div_ovf;

  muldiv_divider #(.XLEN(XLEN)) u_divider (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_i     (div_start),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .w_sel_i     (w_op),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  always_comb begin
    q_fix   = negq_q ? -div_quo : div_quo;
    r_fix   = negr_q ? -div_rem : div_rem;
    sel_res = oprem_q ? r_fix : q_fix;
    div_res = opw_q ? sext_w(sel_res[31:0]) : sel_res;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      illegal_q   <= illegal_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= instruction;
      a_q     <= rs1;
      b_q     <= rs2;
      opw_q   <= w_op;
      oprem_q <= is_rem_op(instruction);
      negq_q  <= a_neg ^ b_neg;
      negr_q  <= a_neg;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!legal)                   state_d = DONE;
          else if (is_mul)              state_d = (MUL_LAT == 1) ? DONE : MUL;
          else if (div_zero || div_ovf) state_d = DONE;
          else                          state_d = DIV;
        end
      end
      MUL:  if (cnt_q == MUL_LAST) state_d = DONE;
      DIV:  if (div_done)          state_d = DONE;
      DONE: if (out_ready)         state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
    if (flush_w) state_d = IDLE;
  end

  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    illegal_d   = illegal_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept && (state_d == DONE)) begin
          out_valid_d = 1'b1;
          illegal_d   = !legal;
          if (!legal)      result_d = '0;
          else if (is_mul) result_d = mul_result(instruction, rs1, rs2);
          else             result_d = special_res;
        end
      end
      MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (state_d == DONE) begin
          out_valid_d = 1'b1;
          illegal_d   = 1'b0;
          result_d    = mul_result(op_q, a_q, b_q);
        end
      end
      DIV: begin
        if (state_d == DONE) begin
          out_valid_d = 1'b1;
          illegal_d   = 1'b0;
          result_d    = div_res;
        end
      end
      DONE: if (out_ready) out_valid_d = 1'b0;
      default: out_valid_d = 1'b0;
    endcase
    if (flush_w) begin
      cnt_d       = '0;
      out_valid_d = 1'b0;
      illegal_d   = 1'b0;
    end
  end

endmodule
